// File: rtl/marv32_pkg.sv
// Shared encodings for the MARV32 data-side AHB units: load funct3 codes,
// HTRANS/HSIZE constants, load-unit FSM states and the load alignment rule.
package marv32_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  typedef enum logic [1:0] {
    LU_IDLE = 2'b00,
    LU_DATA = 2'b01,
    LU_ERR  = 2'b10
  } lu_state_e;

  // Undefined funct3 codes follow the word rule, matching their LW data path.
  function automatic logic lu_aligned(input logic [2:0] funct3, input logic [1:0] off);
    logic ok;
    case (funct3)
      F3_LB, F3_LBU: ok = 1'b1;
      F3_LH, F3_LHU: ok = ~off[0];
      default:       ok = (off == 2'b00);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/marv32_load_extend.sv
// Combinational byte/half lane select of a 32-bit read word plus
// sign/zero extension into the load write-back value.
module marv32_load_extend
  import marv32_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select followed by extension according to the load type.
  always_comb begin
    case (offset_i)
      2'b00:   byte_s = rdata_i[7:0];
      2'b01:   byte_s = rdata_i[15:8];
      2'b10:   byte_s = rdata_i[23:16];
      2'b11:   byte_s = rdata_i[31:24];
      default: byte_s = rdata_i[7:0];
    endcase
    if (offset_i[1]) begin
      half_s = rdata_i[31:16];
    end else begin
      half_s = rdata_i[15:0];
    end
    case (funct3_i)
      F3_LB:   result_o = {{24{byte_s[7]}}, byte_s};
      F3_LBU:  result_o = {24'd0, byte_s};
      F3_LH:   result_o = {{16{half_s[15]}}, half_s};
      F3_LHU:  result_o = {16'd0, half_s};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/marv32_load_unit.sv
// RV32I load unit: issues pipelined AHB-Lite word reads, tracks the data phase
// (wait states, two-cycle ERROR) and returns the extended load result.
module marv32_load_unit
  import marv32_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int ERR_RESP_EN = 1
) (
  input  logic                  clk_in,
  input  logic                  reset_n_in,
  input  logic [2:0]            funct3_in,
  input  logic [ADDR_WIDTH-1:0] iadder_in,
  input  logic                  mem_rd_req_in,
  input  logic                  ahb_ready_in,
  input  logic                  ahb_resp_in,
  input  logic [31:0]           ahb_rdata_in,
  output logic [ADDR_WIDTH-1:0] d_addr_out,
  output logic [1:0]            ahb_htrans_out,
  output logic [2:0]            ahb_hsize_out,
  output logic                  rd_req_out,
  output logic                  req_ready_out,
  output logic [31:0]           lu_output_out,
  output logic                  load_valid_out,
  output logic                  misaligned_out,
  output logic                  access_fault_out,
  output logic                  stall_out
);

  lu_state_e   state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] lu_output_q, lu_output_d;
  logic        load_valid_q, load_valid_d;
  logic        misaligned_q, misaligned_d;
  logic        fault_q, fault_d;

  logic        resp_err_s;
  logic        aligned_s;
  logic        window_s;
  logic [1:0]  htrans_s;
  logic        req_ready_s;
  logic [31:0] ext_s;

  assign resp_err_s = ahb_resp_in & (ERR_RESP_EN != 0);
  assign aligned_s  = lu_aligned(funct3_in, iadder_in[1:0]);

  marv32_load_extend u_extend (
    .funct3_i (funct3_q),
    .offset_i (off_q),
    .rdata_i  (ahb_rdata_in),
    .result_o (ext_s)
  );

  // Next-state, capture and issue logic; a completing data phase reopens the issue window.
  always_comb begin
    state_d      = state_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    lu_output_d  = lu_output_q;
    load_valid_d = 1'b0;
    misaligned_d = 1'b0;
    fault_d      = 1'b0;
    window_s     = 1'b0;
    htrans_s     = HTRANS_IDLE;
    req_ready_s  = 1'b0;

    case (state_q)
      LU_IDLE: begin
        window_s = 1'b1;
      end
      LU_DATA: begin
        if (ahb_ready_in && !resp_err_s) begin
          window_s     = 1'b1;
          lu_output_d  = ext_s;
          load_valid_d = 1'b1;
          state_d      = LU_IDLE;
        end else if (ahb_ready_in) begin
          // Single-cycle ERROR is a protocol violation; still report it as a fault.
          fault_d = 1'b1;
          state_d = LU_IDLE;
        end else if (resp_err_s) begin
          state_d = LU_ERR;
        end else begin
          state_d = state_q;
        end
      end
      LU_ERR: begin
        if (ahb_ready_in) begin
          fault_d = 1'b1;
          state_d = LU_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = LU_IDLE;
      end
    endcase

    if (window_s && mem_rd_req_in) begin
      if (aligned_s) begin
        htrans_s = HTRANS_NONSEQ;
        if (ahb_ready_in) begin
          req_ready_s = 1'b1;
          funct3_d    = funct3_in;
          off_d       = iadder_in[1:0];
          state_d     = LU_DATA;
        end else begin
          req_ready_s = 1'b0;
        end
      end else begin
        req_ready_s  = 1'b1;
        misaligned_d = 1'b1;
      end
    end else begin
      htrans_s = HTRANS_IDLE;
    end
  end

  // State, capture and result registers.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q      <= LU_IDLE;
      funct3_q     <= 3'b000;
      off_q        <= 2'b00;
      lu_output_q  <= 32'd0;
      load_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      lu_output_q  <= lu_output_d;
      load_valid_q <= load_valid_d;
      misaligned_q <= misaligned_d;
      fault_q      <= fault_d;
    end
  end

  assign d_addr_out       = {iadder_in[ADDR_WIDTH-1:2], 2'b00};
  assign ahb_htrans_out   = htrans_s;
  assign ahb_hsize_out    = HSIZE_WORD;
  assign rd_req_out       = (htrans_s == HTRANS_NONSEQ);
  assign req_ready_out    = req_ready_s;
  assign lu_output_out    = lu_output_q;
  assign load_valid_out   = load_valid_q;
  assign misaligned_out   = misaligned_q;
  assign access_fault_out = fault_q;
  assign stall_out        = (mem_rd_req_in & ~req_ready_s)
                          | (((state_q == LU_DATA) || (state_q == LU_ERR)) & ~ahb_ready_in);

endmodule
